// File: rtl/br_update_queue.sv
// br_update_queue: in-order branch-update buffer that splits same-bank pairs across cycles; define BR_UPDATE_QUEUE_BYPASS_EN for same-cycle bypass when empty
module br_update_queue #(
  parameter int ENTRY_NUM = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_SHIFT = 2,
  parameter int IDX_BITS = 8,
  parameter int BANK_BITS = 1,
  parameter int PREV_WIDTH = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic [1:0] in_valid,
  input  logic [1:0][ADDR_WIDTH-1:0] in_addr,
  input  logic [1:0] in_taken,
  input  logic [1:0] in_mispred,
  input  logic [1:0] in_is_cond,
  input  logic [1:0][PREV_WIDTH-1:0] in_prev,
  output logic in_ready,
  output logic [1:0] out_valid,
  output logic [1:0][ADDR_WIDTH-1:0] out_addr,
  output logic [1:0] out_taken,
  output logic [1:0] out_mispred,
  output logic [1:0] out_is_cond,
  output logic [1:0][PREV_WIDTH-1:0] out_prev,
  output logic [$clog2(ENTRY_NUM):0] count,
  output logic [15:0] drop_cnt
);
  localparam int PW = $clog2(ENTRY_NUM);
  localparam int EW = PREV_WIDTH + ADDR_WIDTH + 3;
  logic [EW-1:0] mem [ENTRY_NUM];
  logic [PW:0] head, tail, nin, nout, nst, count_next;
  logic [PW-1:0] h1, t1;
  logic [EW-1:0] in_e0, in_e1, e0, e1, o0, o1, s0;
  logic [1:0] acc, ndrop;
  logic [16:0] drop_sum;
  logic byp;
  function automatic logic clash(input logic [ADDR_WIDTH-1:0] a, input logic [ADDR_WIDTH-1:0] b);
    return a[INSN_SHIFT +: BANK_BITS] == b[INSN_SHIFT +: BANK_BITS] || a[INSN_SHIFT +: IDX_BITS] == b[INSN_SHIFT +: IDX_BITS];
  endfunction
`ifdef BR_UPDATE_QUEUE_BYPASS_EN
  assign byp = count == '0;
`else
  assign byp = 1'b0;
`endif
  always_comb begin
    in_e0 = {in_prev[0], in_is_cond[0], in_mispred[0], in_taken[0], in_addr[0]};
    in_e1 = {in_prev[1], in_is_cond[1], in_mispred[1], in_taken[1], in_addr[1]};
    acc = in_valid & {2{in_ready}};
    e0 = acc[0] ? in_e0 : in_e1;
    e1 = in_e1;
    h1 = head[PW-1:0] + 1'b1;
    t1 = tail[PW-1:0] + 1'b1;
    o0 = byp ? e0 : mem[head[PW-1:0]];
    o1 = byp ? e1 : mem[h1];
    out_valid[0] = byp ? |acc : head != tail;
    out_valid[1] = (byp ? &acc : count > (PW+1)'(1)) && !clash(o0[ADDR_WIDTH-1:0], o1[ADDR_WIDTH-1:0]);
    nin = (PW+1)'(acc[0]) + (PW+1)'(acc[1]);
    nout = (PW+1)'(out_valid[0]) + (PW+1)'(out_valid[1]);
    nst = byp ? nin - nout : nin;
    s0 = (byp && out_valid[0]) ? e1 : e0;
    count_next = count + nin - nout;
    ndrop = in_ready ? 2'd0 : {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
    drop_sum = {1'b0, drop_cnt} + {15'd0, ndrop};
    out_addr[0] = o0[ADDR_WIDTH-1:0];
    out_addr[1] = o1[ADDR_WIDTH-1:0];
    out_taken = {o1[ADDR_WIDTH], o0[ADDR_WIDTH]};
    out_mispred = {o1[ADDR_WIDTH+1], o0[ADDR_WIDTH+1]};
    out_is_cond = {o1[ADDR_WIDTH+2], o0[ADDR_WIDTH+2]};
    out_prev[0] = o0[EW-1 -: PREV_WIDTH];
    out_prev[1] = o1[EW-1 -: PREV_WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      in_ready <= 1'b1;
      drop_cnt <= '0;
    end else begin
      head <= head + (byp ? '0 : nout);
      tail <= tail + nst;
      count <= count_next;
      in_ready <= count_next <= (PW+1)'(ENTRY_NUM - 2);
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
  always_ff @(posedge clk) begin
    if (nst != '0) mem[tail[PW-1:0]] <= s0;
    if (nst == (PW+1)'(2)) mem[t1] <= e1;
  end
endmodule

// File: tb/tb_br_update_queue.sv
// tb_br_update_queue: randomized scoreboard bench for br_update_queue
module tb_br_update_queue;
  localparam int N = 8;
  typedef struct packed {
    logic [39:0] prev;
    logic is_cond;
    logic mispred;
    logic taken;
    logic [31:0] addr;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] in_valid = '0;
  logic [1:0][31:0] in_addr = '0;
  logic [1:0] in_taken = '0;
  logic [1:0] in_mispred = '0;
  logic [1:0] in_is_cond = '0;
  logic [1:0][39:0] in_prev = '0;
  logic in_ready;
  logic [1:0] out_valid;
  logic [1:0][31:0] out_addr;
  logic [1:0] out_taken;
  logic [1:0] out_mispred;
  logic [1:0] out_is_cond;
  logic [1:0][39:0] out_prev;
  logic [3:0] count;
  logic [15:0] drop_cnt;
  ent_t mq[$];
  ent_t stage[$];
  int stage_drop = 0;
  int drop_exp = 0;
  int pass_n = 0;
  int check_n = 0;
  bit ready_exp = 1'b1;
  br_update_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_taken(in_taken),
    .in_mispred(in_mispred), .in_is_cond(in_is_cond), .in_prev(in_prev), .in_ready(in_ready),
    .out_valid(out_valid), .out_addr(out_addr), .out_taken(out_taken), .out_mispred(out_mispred),
    .out_is_cond(out_is_cond), .out_prev(out_prev), .count(count), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  function automatic bit clash(input logic [31:0] a, input logic [31:0] b);
    int ia = int'((a >> 2) % 256);
    int ib = int'((b >> 2) % 256);
    return ia == ib || ia % 2 == ib % 2;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    check_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
    ent_t e;
    in_valid = v;
    in_addr[0] = a0;
    in_addr[1] = a1;
    in_taken = 2'($urandom);
    in_mispred = 2'($urandom);
    in_is_cond = 2'($urandom);
    in_prev[0] = {8'($urandom), 32'($urandom)};
    in_prev[1] = {8'($urandom), 32'($urandom)};
    if (!ready_exp) stage_drop = int'(v[0]) + int'(v[1]);
    else for (int i = 0; i < 2; i++) if (v[i]) begin
      e = '{in_prev[i], in_is_cond[i], in_mispred[i], in_taken[i], in_addr[i]};
      stage.push_back(e);
    end
  endtask
  task automatic cyc(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
    tick();
    drive(v, a0, a1);
  endtask
  task automatic reset_now();
    rst = 1'b1;
    in_valid = '0;
    tick();
    rst = 1'b0;
  endtask
  always @(negedge clk) begin : monitor
    logic [1:0] ov_exp;
    ov_exp[0] = mq.size() > 0;
    ov_exp[1] = mq.size() > 1 && !clash(mq[0].addr, mq[1].addr);
    chk("count", count, mq.size());
    chk("in_ready", in_ready, ready_exp);
    chk("drop_cnt", drop_cnt, drop_exp);
    chk("out_valid", out_valid, ov_exp);
    for (int i = 0; i < 2; i++)
      if (out_valid[i] && i < mq.size())
        chk($sformatf("lane%0d_payload", i), {out_prev[i], out_is_cond[i], out_mispred[i], out_taken[i], out_addr[i]}, mq[i]);
    for (int i = 0; i < 2; i++) if (ov_exp[i]) void'(mq.pop_front());
    if (rst) begin
      mq.delete();
      drop_exp = 0;
      ready_exp = 1'b1;
    end else begin
      while (stage.size() > 0) mq.push_back(stage.pop_front());
      drop_exp = (drop_exp + stage_drop > 65535) ? 65535 : drop_exp + stage_drop;
      ready_exp = (N - mq.size()) >= 2;
    end
    stage.delete();
    stage_drop = 0;
  end
  initial begin
    logic [31:0] a0, a1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc(2'b01, 32'h100, 32'h0);
    repeat (2) cyc(2'b00, 32'h0, 32'h0);
    cyc(2'b11, 32'h100, 32'h104);
    repeat (2) cyc(2'b00, 32'h0, 32'h0);
    cyc(2'b11, 32'h100, 32'h108);
    repeat (3) cyc(2'b00, 32'h0, 32'h0);
    for (int k = 0; k < 8; k++) cyc(2'b11, 32'h100 + 32'(16 * k), 32'h108 + 32'(16 * k));
    repeat (12) cyc(2'b00, 32'h0, 32'h0);
    for (int g = 0; g < 40; g++) begin
      tick();
      if (mq.size() == 5) break;
      drive(2'b11, 32'h200 + 32'(16 * g), 32'h208 + 32'(16 * g));
    end
    reset_now();
    repeat (2) cyc(2'b00, 32'h0, 32'h0);
    for (int k = 0; k < 400; k++) begin
      a0 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h1000 + 32'($urandom_range(0, 7) << 2);
      a1 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h1000 + 32'($urandom_range(0, 7) << 2);
      tick();
      if ($urandom_range(0, 99) == 0) reset_now();
      else drive(2'($urandom), a0, a1);
    end
    repeat (12) cyc(2'b00, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_n, check_n);
    $finish;
  end
endmodule
